// File: rtl/spi_xfer.sv
// SPI mode-0 master, MSB first, one byte per request, full duplex.
// Optional miso two-flop synchronizer: define SPI_XFER_MISO_SYNC_EN (needs DIV >= 3 for loopback timing).
module spi_xfer #(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [7:0] idata,
    input  logic       wr,
    output logic [7:0] odata,
    output logic       dsr,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    if (DIV < 1 || DIV > 255) begin : g_bad_div
        $error("spi_xfer: DIV must be within 1..255");
    end

    localparam logic [7:0] PHASE_LOAD = 8'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  phase_q, phase_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        dsr_q, dsr_d;
    logic        busy_q, busy_d;
    logic [7:0]  odata_q, odata_d;
    logic        miso_s;

    logic        phase_zero;
    assign phase_zero = (phase_q == 8'd0);

`ifdef SPI_XFER_MISO_SYNC_EN
    // Free-running on clk so the synchronizer settles independently of ce.
    logic [1:0] miso_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_sync_q <= 2'b11;
        end else begin
            miso_sync_q <= {miso_sync_q[0], miso};
        end
    end

    assign miso_s = miso_sync_q[1];
`else
    assign miso_s = miso;
`endif

    // NOTE: sequential state uses non-blocking assignments only; the comb blocks compute _d values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (ce) begin
            unique case (state_q)
                IDLE: if (wr) state_d = LOW;
                LOW:  if (phase_zero) state_d = HIGH;
                HIGH: if (phase_zero) state_d = (bit_q != 3'd0) ? LOW : DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d = shift_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        dsr_d   = dsr_q;
        busy_d  = busy_q;
        odata_d = odata_q;
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    sck_d  = 1'b0;
                    mosi_d = 1'b1;
                    if (wr) begin
                        shift_d = idata;
                        mosi_d  = idata[7];
                        busy_d  = 1'b1;
                        bit_d   = 3'd7;
                        phase_d = PHASE_LOAD;
                    end
                end
                LOW: begin
                    if (phase_zero) begin
                        sck_d   = 1'b1;
                        shift_d = {shift_q[6:0], miso_s};
                        phase_d = PHASE_LOAD;
                    end else begin
                        phase_d = phase_q - 8'd1;
                    end
                end
                HIGH: begin
                    if (phase_zero) begin
                        sck_d = 1'b0;
                        if (bit_q != 3'd0) begin
                            bit_d   = bit_q - 3'd1;
                            mosi_d  = shift_q[7];
                            phase_d = PHASE_LOAD;
                        end else begin
                            // Outputs of DONE are registered on entry so they appear in the DONE cycle.
                            odata_d = shift_q;
                            dsr_d   = 1'b1;
                            busy_d  = 1'b0;
                            mosi_d  = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q - 8'd1;
                    end
                end
                DONE: begin
                    dsr_d = 1'b0;
                end
                default: begin
                    dsr_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= 8'hFF;
            bit_q   <= 3'd0;
            phase_q <= 8'd0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            dsr_q   <= 1'b0;
            busy_q  <= 1'b0;
            odata_q <= 8'h00;
        end else begin
            shift_q <= shift_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            dsr_q   <= dsr_d;
            busy_q  <= busy_d;
            odata_q <= odata_d;
        end
    end

    assign odata = odata_q;
    assign dsr   = dsr_q;
    assign busy  = busy_q;
    assign sck   = sck_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_xfer.sv
// Directed bench for spi_xfer: three instances with DIV=1, 2, 3 sharing clk and reset.
module tb_spi_xfer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] ce, wr, miso, sck, mosi, dsr, busy;
    logic [7:0] idata [3];
    logic [7:0] odata [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_xfer #(.DIV(1)) u_dut0 (.clk(clk), .reset_n(reset_n), .ce(ce[0]), .idata(idata[0]), .wr(wr[0]),
        .odata(odata[0]), .dsr(dsr[0]), .busy(busy[0]), .sck(sck[0]), .mosi(mosi[0]), .miso(miso[0]));
    spi_xfer #(.DIV(2)) u_dut1 (.clk(clk), .reset_n(reset_n), .ce(ce[1]), .idata(idata[1]), .wr(wr[1]),
        .odata(odata[1]), .dsr(dsr[1]), .busy(busy[1]), .sck(sck[1]), .mosi(mosi[1]), .miso(miso[1]));
    spi_xfer #(.DIV(3)) u_dut2 (.clk(clk), .reset_n(reset_n), .ce(ce[2]), .idata(idata[2]), .wr(wr[2]),
        .odata(odata[2]), .dsr(dsr[2]), .busy(busy[2]), .sck(sck[2]), .mosi(mosi[2]), .miso(miso[2]));

`ifdef SPI_XFER_MISO_SYNC_EN
    localparam bit LOOP0_OK = 1'b0;
`else
    localparam bit LOOP0_OK = 1'b1;
`endif

    // Slave models: DUT0/DUT2 loop mosi back, DUT1 shifts out a pattern advanced on each sck rise.
    int         rises0 = 0, rises1 = 0, base1 = 0;
    time        lr0 = 0, per0 = 0, lr1 = 0, per1 = 0;
    logic [7:0] mlog0 = 8'h00;
    logic [7:0] pat1 = 8'h00;
    logic [7:0] pat_sh;
    int         dsr_clks = 0, dsr_base = 0;
    bit         tog = 1'b0;
    time        dsr_t = 0;

    always_comb pat_sh = pat1 << (rises1 - base1);
    assign miso[0] = mosi[0];
    assign miso[1] = pat_sh[7];
    assign miso[2] = mosi[2];

    always @(posedge sck[0]) begin
        mlog0  <= {mlog0[6:0], mosi[0]};
        rises0 <= rises0 + 1;
        per0   <= $time - lr0;
        lr0    <= $time;
    end

    always @(posedge sck[1]) begin
        rises1 <= rises1 + 1;
        per1   <= $time - lr1;
        lr1    <= $time;
    end

    always @(negedge clk) if (dsr[0]) dsr_clks <= dsr_clks + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One ce cycle; with tog set, a ce=0 clock precedes it.
    task automatic tick(input int i);
        if (tog) begin
            ce[i] = 1'b0;
            @(posedge clk); #1;
        end
        ce[i] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic xfer(input int i, input logic [7:0] d, input logic [7:0] exp, input int lat,
                        input bit noise, input bit chk_data, input bit done_wr);
        int n;
        idata[i] = d;
        wr[i] = 1'b1;
        tick(i);
        wr[i] = 1'b0;
        check("busy_set", busy[i], 1);
        n = 1;
        while (!dsr[i] && n < 2000) begin
            if (noise && (n == 5 || n == 6)) begin
                wr[i] = 1'b1;
                idata[i] = ~d;
            end else begin
                wr[i] = 1'b0;
            end
            tick(i);
            n++;
        end
        wr[i] = 1'b0;
        dsr_t = $time;
        check("latency", n, lat);
        if (chk_data) check("odata", odata[i], exp);
        check("busy_done", busy[i], 0);
        if (done_wr) wr[i] = 1'b1;
        tick(i);
        wr[i] = 1'b0;
        check("dsr_one", dsr[i], 0);
        if (done_wr) check("done_wr_ignored", busy[i], 0);
        if (i == 0) begin
            check("dsr_clks", dsr_clks - dsr_base, tog ? 2 : 1);
            dsr_base = dsr_clks;
        end
    endtask

    initial begin
        time t0;
        int  r0, hits;
        reset_n = 1'b0;
        ce = 3'b111;
        wr = 3'b000;
        for (int i = 0; i < 3; i++) idata[i] = 8'h00;
        #12;
        check("rst_sck", sck[0], 0);
        check("rst_mosi", mosi[0], 1);
        check("rst_busy", busy[0], 0);
        check("rst_dsr", dsr[0], 0);
        check("rst_odata", odata[0], 8'h00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick(0);
        check("idle_mosi", mosi[0], 1);

        // DIV=1 loopback of A5, also a wr during the dsr cycle that must not start anything
        r0 = rises0;
        xfer(0, 8'hA5, 8'hA5, 17, 1'b0, LOOP0_OK, 1'b1);
        check("mosi_bits", mlog0, 8'hA5);
        check("sck_rises", rises0 - r0, 8);
        check("sck_per_div1", 32'(per0), 20);

        // DIV=2, slave returns 3C
        pat1 = 8'h3C;
        base1 = rises1;
        xfer(1, 8'hFF, 8'h3C, 33, 1'b0, 1'b1, 1'b0);
        check("sck_per_div2", 32'(per1), 40);
        check("sck_rises1", rises1 - base1, 8);

        // back-to-back with wr noise while busy
        xfer(0, 8'h01, 8'h01, 17, 1'b1, LOOP0_OK, 1'b0);
        t0 = dsr_t;
        xfer(0, 8'h80, 8'h80, 17, 1'b0, LOOP0_OK, 1'b0);
        check("b2b_gap1", 32'((dsr_t - t0) / 10), 18);
        t0 = dsr_t;
        xfer(0, 8'h7E, 8'h7E, 17, 1'b1, LOOP0_OK, 1'b0);
        check("b2b_gap2", 32'((dsr_t - t0) / 10), 18);
        check("b2b_mosi", mlog0, 8'h7E);

        // ce toggling 1/0 stretches everything by 2x
        tog = 1'b1;
        xfer(0, 8'h96, 8'h96, 17, 1'b0, LOOP0_OK, 1'b0);
        check("sck_per_tog", 32'(per0), 40);
        check("mosi_tog", mlog0, 8'h96);
        tog = 1'b0;

        // reset mid-transfer around bit 4
        idata[0] = 8'h3C;
        wr[0] = 1'b1;
        tick(0);
        wr[0] = 1'b0;
        for (int k = 0; k < 8; k++) tick(0);
        check("mid_busy", busy[0], 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_sck", sck[0], 0);
        check("abort_mosi", mosi[0], 1);
        check("abort_busy", busy[0], 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            tick(0);
            if (dsr[0]) hits++;
        end
        check("abort_no_dsr", hits, 0);
        dsr_base = dsr_clks;
        xfer(0, 8'h55, 8'h55, 17, 1'b0, LOOP0_OK, 1'b0);
        check("after_rst_mosi", mlog0, 8'h55);

        // DIV=3 loopback, valid with or without the miso synchronizer
        xfer(2, 8'hC3, 8'hC3, 49, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_xfer.md
SPI_XFER -- requirements
Module: spi_xfer

Interface
REQ-001 SHALL have parameter DIV, default 1, meaning SCK half-period in ce-qualified clk cycles (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port ce  input  1  clock enable; when 0, all registers hold.
REQ-005 SHALL have port idata  input  8  byte to transmit, driven by the DMA engine's SPI data output.
REQ-006 SHALL have port wr  input  1  transfer request, sampled when ce=1.
REQ-007 SHALL have port odata  output  8  last received byte, registered.
REQ-008 SHALL have port dsr  output  1  data-ready pulse, registered.
REQ-009 SHALL have port busy  output  1  transfer in progress, registered.
REQ-010 SHALL have ports sck (output, 1, SPI clock), mosi (output, 1, SPI data out) and miso (input, 1, SPI data in).

Function
REQ-011 SHALL implement SPI mode 0, MSB first, 8 bits per transfer, full duplex.
REQ-012 SHALL use states IDLE, LOW, HIGH, DONE.
REQ-013 IDLE: on ce=1 and wr=1, SHALL latch idata into an 8-bit shift register, drive mosi=idata[7], set busy=1, load bit counter=7 and phase counter=DIV-1, and go to LOW.
REQ-014 IDLE with wr=0: SHALL hold with sck=0 and mosi=1.
REQ-015 LOW: sck=0; when the phase counter reaches 0, SHALL set sck=1, shift miso (per REQ-026) into the shift register LSB, reload the phase counter, and go to HIGH.
REQ-016 HIGH: sck=1; when the phase counter reaches 0, SHALL set sck=0; if bit counter≠0, decrement it, drive mosi from the new shift-register MSB and go to LOW; else go to DONE.
REQ-017 DONE (one ce cycle): SHALL load odata from the shift register, pulse dsr=1, set busy=0, drive mosi=1, and go to IDLE.
REQ-018 dsr SHALL be high for exactly one ce cycle per transfer, because the requesting DMA engine counts one byte per dsr cycle.
REQ-019 Latency: dsr SHALL be high in the ce cycle that is 16*DIV+1 ce cycles after the ce cycle in which wr was sampled.
REQ-020 wr SHALL be ignored while busy=1; it is neither queued nor allowed to corrupt the shift register.
REQ-021 wr asserted in the cycle dsr=1 SHALL NOT start a transfer. wr asserted in the cycle after dsr SHALL start the next transfer with no extra gap.
REQ-022 odata SHALL change only in DONE and hold its value between transfers.
REQ-023 Counters SHALL be 3-bit (bit) and 8-bit (phase), and SHALL NOT wrap beyond the state transitions above.

Reset
REQ-024 reset_n=0 SHALL asynchronously force state=IDLE, sck=0, mosi=1, dsr=0, busy=0, odata=8'h00, shift register=8'hFF, and counters=0.
REQ-025 Reset mid-transfer SHALL abort the transfer with no dsr pulse. The first wr after reset release SHALL start a fresh transfer.

Configuration
REQ-026 Macro SPI_XFER_MISO_SYNC_EN: when defined, miso SHALL pass through a two-flop synchronizer clocked by clk (not gated by ce), and the LOW-to-HIGH sample SHALL use the synchronized value. When undefined, miso SHALL be sampled directly. REQ-019 latency SHALL be unchanged in both cases. With the macro defined, DIV>=3 is required for correct data at the slave round-trip.

Verification
REQ-027 DIV=1, ce=1, idata=8'hA5, wr pulse, miso looped to mosi -> mosi shows 1,0,1,0,0,1,0,1 with 8 sck rising edges; dsr=1 exactly at cycle 17; odata=8'hA5; busy low after.
REQ-028 DIV=2, idata=8'hFF, miso driving 8'h3C MSB first -> odata=8'h3C; dsr at cycle 33; sck period 4 cycles.
REQ-029 Back-to-back: wr one cycle after each dsr, 3 bytes 8'h01, 8'h80, 8'h7E -> three single-cycle dsr pulses spaced 18 cycles apart (DIV=1); extra wr pulses while busy are ignored.
REQ-030 ce toggling 1/0 with DIV=1 -> identical waveforms stretched by 2x; dsr high exactly one ce cycle.
REQ-031 reset_n low at bit 4 of a transfer -> sck=0, mosi=1, busy=0 immediately; no dsr; next wr with 8'h55 completes correctly.
REQ-032 With SPI_XFER_MISO_SYNC_EN defined, DIV=3, loopback 8'hC3 -> odata=8'hC3, dsr at cycle 49.
